// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, operand limits and sequencer state encoding shared by the ALU command path
package alu_pkg;

   localparam logic [5:0] OP_CLEAR = 6'd0;
   localparam logic [5:0] OP_NOT   = 6'd1;
   localparam logic [5:0] OP_SHR   = 6'd2;
   localparam logic [5:0] OP_SHL   = 6'd3;
   localparam logic [5:0] OP_FACT  = 6'd4;
   localparam logic [5:0] OP_EXP   = 6'd5;
   localparam logic [5:0] OP_ADD   = 6'd6;
   localparam logic [5:0] OP_SUB   = 6'd7;
   localparam logic [5:0] OP_MULT  = 6'd8;
   localparam logic [5:0] OP_DIV   = 6'd9;
   localparam logic [5:0] OP_AND   = 6'd10;
   localparam logic [5:0] OP_OR    = 6'd11;
   localparam logic [5:0] OP_XOR   = 6'd12;
   localparam logic [5:0] OP_MAX   = OP_XOR;

   localparam logic [15:0] FACT_MAX_IN = 16'd12;
   localparam logic [15:0] EXP_MAX_IN  = 16'd22;
   localparam logic [31:0] ERR_DATA    = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } seq_state_e;

endpackage

// File: rtl/alu_err_check.sv
// rtl/alu_err_check.sv - combinational error/accumulator-write decision for one ALU operation
module alu_err_check
   import alu_pkg::*;
(
   input  logic [5:0]  alu_sel,
   input  logic [15:0] alu_a,
   input  logic [15:0] alu_b,
   input  logic [31:0] alu_out,
   output logic        err,
   output logic        acc_we,
   output logic [31:0] rsp_data
);

   logic [16:0] sum17;
   logic        hard_err;
   logic        soft_err;

   assign sum17 = {1'b0, alu_a} + {1'b0, alu_b};

   // Hard errors poison the result; soft errors (overflow/borrow) still keep it.
   always_comb begin
      hard_err = 1'b0;
      soft_err = 1'b0;
      case (alu_sel)
         OP_DIV:  hard_err = (alu_b == 16'd0);
         OP_FACT: hard_err = (alu_a > FACT_MAX_IN);
         OP_EXP:  hard_err = (alu_a > EXP_MAX_IN);
         OP_ADD:  soft_err = sum17[16];
         OP_SUB:  soft_err = (alu_a < alu_b);
         default: ;
      endcase
   end

   assign err      = hard_err | soft_err;
   assign acc_we   = ~hard_err;
   assign rsp_data = hard_err ? ERR_DATA : alu_out;

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - one-at-a-time command sequencer driving the ALU inputs and owning the accumulator
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int MAX_OP        = int'(OP_MAX)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_op,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   input  logic        cmd_use_acc,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [5:0]  alu_sel,
   output logic [31:0] alu_acc,
   input  logic [31:0] alu_out,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [31:0] acc_q
);

   seq_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] alu_a_q, alu_a_d;
   logic [15:0] alu_b_q, alu_b_d;
   logic [5:0]  alu_sel_q, alu_sel_d;
   logic [31:0] acc_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_data_q, rsp_data_d;

   logic        chk_err;
   logic        chk_acc_we;
   logic [31:0] chk_data;

   alu_err_check u_err_check (
      .alu_sel  (alu_sel_q),
      .alu_a    (alu_a_q),
      .alu_b    (alu_b_q),
      .alu_out  (alu_out),
      .err      (chk_err),
      .acc_we   (chk_acc_we),
      .rsp_data (chk_data)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_sel_d   = alu_sel_q;
      acc_d       = acc_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_op > 6'(MAX_OP)) begin
                  // Rejected opcodes never touch the ALU port set.
                  rsp_data_d  = ERR_DATA;
                  rsp_err_d   = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = ST_RESP;
               end else begin
                  alu_sel_d = cmd_op;
                  alu_b_d   = cmd_b;
                  alu_a_d   = cmd_use_acc ? acc_q[15:0] : cmd_a;
                  cnt_d     = 4'(SETTLE_CYCLES - 1);
                  state_d   = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rsp_data_d  = chk_data;
               rsp_err_d   = chk_err;
               rsp_valid_d = 1'b1;
               if (chk_acc_we) acc_d = alu_out;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         alu_a_q     <= 16'd0;
         alu_b_q     <= 16'd0;
         alu_sel_q   <= 6'd0;
         acc_q       <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sel_q   <= alu_sel_d;
         acc_q       <= acc_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign alu_acc   = acc_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid1, cmd_valid4;
   logic [5:0]  cmd_op;
   logic [15:0] cmd_a, cmd_b;
   logic        cmd_use_acc;
   logic        rsp_ready;

   logic        cmd_ready1, rsp_valid1, rsp_err1;
   logic [15:0] alu_a1, alu_b1;
   logic [5:0]  alu_sel1;
   logic [31:0] alu_acc1, alu_out1, rsp_data1, acc1;

   logic        cmd_ready4, rsp_valid4, rsp_err4;
   logic [15:0] alu_a4, alu_b4;
   logic [5:0]  alu_sel4;
   logic [31:0] alu_acc4, alu_out4, rsp_data4, acc4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_model(input logic [5:0] sel, input logic [15:0] a,
                                             input logic [15:0] b, input logic [31:0] acc);
      logic [31:0] r;
      case (sel)
         6'd0:  r = 32'd0;
         6'd1:  r = ~acc;
         6'd2:  r = acc >> 1;
         6'd3:  r = acc << 1;
         6'd4: begin
            r = 32'd1;
            if (a > 16'd12) r = 32'd0;
            else for (int i = 2; i <= int'(a); i++) r = r * 32'(i);
         end
         6'd5:  r = 32'd1 << a[4:0];
         6'd6:  r = {16'd0, a} + {16'd0, b};
         6'd7:  r = {16'd0, a} - {16'd0, b};
         6'd8:  r = {16'd0, a} * {16'd0, b};
         6'd9:  r = (b == 16'd0) ? 32'd0 : {16'd0, a / b};
         6'd10: r = {16'd0, a & b};
         6'd11: r = {16'd0, a | b};
         default: r = {16'd0, a ^ b};
      endcase
      return r;
   endfunction

   always_comb alu_out1 = alu_model(alu_sel1, alu_a1, alu_b1, alu_acc1);
   always_comb alu_out4 = alu_model(alu_sel4, alu_a4, alu_b4, alu_acc4);

   alu_op_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
      .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1), .alu_acc(alu_acc1),
      .alu_out(alu_out1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data1), .rsp_err(rsp_err1), .acc_q(acc1)
   );

   alu_op_sequencer #(.SETTLE_CYCLES(4)) u_dut4 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
      .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4), .alu_acc(alu_acc4),
      .alu_out(alu_out4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data4), .rsp_err(rsp_err4), .acc_q(acc4)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic use_acc);
      cmd_op      = op;
      cmd_a       = a;
      cmd_b       = b;
      cmd_use_acc = use_acc;
   endtask

   // Issue on the SETTLE_CYCLES=1 instance, let it complete, and leave the response on the port.
   task automatic run1(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic use_acc);
      set_cmd(op, a, b, use_acc);
      cmd_valid1 = 1'b1;
      tick();
      cmd_valid1 = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b0;
      cmd_valid1 = 1'b0;
      cmd_valid4 = 1'b0;
      rsp_ready = 1'b1;
      set_cmd(6'd0, 16'd0, 16'd0, 1'b0);
      repeat (2) tick();
      check_eq("rst_rsp_valid", {31'd0, rsp_valid1}, 32'd0);
      check_eq("rst_acc", acc1, 32'd0);
      check_eq("rst_alu_sel", {26'd0, alu_sel1}, 32'd0);
      check_eq("rst_cmd_ready", {31'd0, cmd_ready1}, 32'd1);
      #2 reset = 1'b1;
      tick();

      // add 3+4: response one edge after accept
      set_cmd(6'd6, 16'd3, 16'd4, 1'b0);
      cmd_valid1 = 1'b1;
      tick();
      cmd_valid1 = 1'b0;
      check_eq("add_exec_ready", {31'd0, cmd_ready1}, 32'd0);
      check_eq("add_exec_valid", {31'd0, rsp_valid1}, 32'd0);
      check_eq("add_alu_a", {16'd0, alu_a1}, 32'd3);
      check_eq("add_alu_sel", {26'd0, alu_sel1}, 32'd6);
      tick();
      check_eq("add_rsp_valid", {31'd0, rsp_valid1}, 32'd1);
      check_eq("add_rsp_data", rsp_data1, 32'd7);
      check_eq("add_rsp_err", {31'd0, rsp_err1}, 32'd0);
      check_eq("add_acc", acc1, 32'd7);
      check_eq("add_resp_ready", {31'd0, cmd_ready1}, 32'd0);
      tick();
      check_eq("add_idle_valid", {31'd0, rsp_valid1}, 32'd0);
      check_eq("add_idle_ready", {31'd0, cmd_ready1}, 32'd1);

      // mult using accumulator as operand A
      run1(6'd8, 16'd999, 16'd6, 1'b1);
      check_eq("mult_alu_a", {16'd0, alu_a1}, 32'd7);
      check_eq("mult_rsp_data", rsp_data1, 32'd42);
      check_eq("mult_acc", acc1, 32'd42);
      tick();

      run1(6'd9, 16'd10, 16'd0, 1'b0);
      check_eq("div0_err", {31'd0, rsp_err1}, 32'd1);
      check_eq("div0_data", rsp_data1, 32'hFFFF_FFFF);
      check_eq("div0_acc", acc1, 32'd42);
      tick();

      run1(6'd4, 16'd13, 16'd0, 1'b0);
      check_eq("fact13_err", {31'd0, rsp_err1}, 32'd1);
      check_eq("fact13_acc", acc1, 32'd42);
      tick();

      // illegal opcode: single edge, ALU regs untouched
      set_cmd(6'd20, 16'd1, 16'd1, 1'b0);
      cmd_valid1 = 1'b1;
      tick();
      cmd_valid1 = 1'b0;
      check_eq("ill_rsp_valid", {31'd0, rsp_valid1}, 32'd1);
      check_eq("ill_rsp_err", {31'd0, rsp_err1}, 32'd1);
      check_eq("ill_rsp_data", rsp_data1, 32'hFFFF_FFFF);
      check_eq("ill_alu_sel", {26'd0, alu_sel1}, 32'd4);
      check_eq("ill_acc", acc1, 32'd42);
      tick();
      check_eq("ill_idle_err", {31'd0, rsp_err1}, 32'd0);

      // back-pressure with a second command held on the bus
      rsp_ready = 1'b0;
      run1(6'd7, 16'd9, 16'd2, 1'b0);
      set_cmd(6'd6, 16'd1, 16'd1, 1'b0);
      cmd_valid1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_rsp_valid", {31'd0, rsp_valid1}, 32'd1);
         check_eq("bp_rsp_data", rsp_data1, 32'd7);
         check_eq("bp_cmd_ready", {31'd0, cmd_ready1}, 32'd0);
         tick();
      end
      check_eq("bp_acc", acc1, 32'd7);
      rsp_ready = 1'b1;
      tick();
      check_eq("bp_release_valid", {31'd0, rsp_valid1}, 32'd0);
      check_eq("bp_release_ready", {31'd0, cmd_ready1}, 32'd1);
      tick();
      cmd_valid1 = 1'b0;
      check_eq("bp_held_accept", {31'd0, cmd_ready1}, 32'd0);
      check_eq("bp_held_sel", {26'd0, alu_sel1}, 32'd6);
      tick();
      check_eq("bp_held_data", rsp_data1, 32'd2);
      check_eq("bp_held_acc", acc1, 32'd2);
      tick();

      // add carry-out: flagged but still accumulated
      run1(6'd6, 16'hFFFF, 16'd1, 1'b0);
      check_eq("carry_err", {31'd0, rsp_err1}, 32'd1);
      check_eq("carry_data", rsp_data1, 32'h0001_0000);
      check_eq("carry_acc", acc1, 32'h0001_0000);
      tick();

      // SETTLE_CYCLES=4 instance: normal op then reset mid-EXEC
      set_cmd(6'd6, 16'd3, 16'd4, 1'b0);
      cmd_valid4 = 1'b1;
      tick();
      cmd_valid4 = 1'b0;
      repeat (3) begin
         tick();
         check_eq("s4_wait_valid", {31'd0, rsp_valid4}, 32'd0);
      end
      tick();
      check_eq("s4_rsp_valid", {31'd0, rsp_valid4}, 32'd1);
      check_eq("s4_rsp_data", rsp_data4, 32'd7);
      check_eq("s4_acc", acc4, 32'd7);
      tick();

      set_cmd(6'd8, 16'd5, 16'd5, 1'b0);
      cmd_valid4 = 1'b1;
      tick();
      cmd_valid4 = 1'b0;
      tick();
      #2 reset = 1'b0;
      #1;
      check_eq("mid_rst_alu_a", {16'd0, alu_a4}, 32'd0);
      check_eq("mid_rst_alu_sel", {26'd0, alu_sel4}, 32'd0);
      check_eq("mid_rst_acc", acc4, 32'd0);
      check_eq("mid_rst_rsp_data", rsp_data4, 32'd0);
      check_eq("mid_rst_cmd_ready", {31'd0, cmd_ready4}, 32'd1);
      tick();
      reset = 1'b1;
      repeat (4) begin
         tick();
         check_eq("post_rst_no_rsp", {31'd0, rsp_valid4}, 32'd0);
      end

      set_cmd(6'd0, 16'h0055, 16'd0, 1'b0);
      cmd_valid4 = 1'b1;
      tick();
      cmd_valid4 = 1'b0;
      repeat (3) tick();
      check_eq("clr_early_valid", {31'd0, rsp_valid4}, 32'd0);
      tick();
      check_eq("clr_rsp_valid", {31'd0, rsp_valid4}, 32'd1);
      check_eq("clr_rsp_data", rsp_data4, 32'd0);
      check_eq("clr_acc", acc4, 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side driver for the 16-bit ALU. It accepts one operation at a time over a valid/ready command interface.
- It registers the operands and opcode onto the ALU input port set, then waits a fixed settle time.
- It captures the 32-bit ALU result into the architectural accumulator and returns it on a valid/ready response interface.
- It replaces the free-running operand DFFs and accumulator currently wired around the ALU.

Parameters:
- SETTLE_CYCLES, 1, clock edges between driving ALU inputs and sampling alu_out; legal range 1..15.
- MAX_OP, 12, highest legal opcode; 0 clear, 1 not, 2 shr, 3 shl, 4 fact, 5 exp, 6 add, 7 sub, 8 mult, 9 div, 10 and, 11 or, 12 xor.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  6  opcode
- cmd_a  in  16  operand A
- cmd_b  in  16  operand B
- cmd_use_acc  in  1  when 1, operand A is taken from acc_q[15:0] instead of cmd_a
- alu_a  out  16  to ALU a
- alu_b  out  16  to ALU b
- alu_sel  out  6  to ALU sel
- alu_acc  out  32  to ALU acc; always equals acc_q
- alu_out  in  32  ALU result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  32  result
- rsp_err  out  1  operation error
- acc_q  out  32  accumulator

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - state=IDLE.
  - alu_a, alu_b, alu_sel, acc_q, rsp_data, settle counter all 0; rsp_valid=0, rsp_err=0.
  - An in-flight command is discarded with no response.
- FSM states: IDLE, EXEC, RESP.
- cmd_ready = (state==IDLE). It is combinational from state only, with no dependence on cmd_valid.
- IDLE, on cmd_valid=1 at an edge:
  - Legal op (cmd_op <= MAX_OP): load alu_sel=cmd_op, alu_b=cmd_b, alu_a=(cmd_use_acc ? acc_q[15:0] : cmd_a). Load counter=SETTLE_CYCLES-1. Go to EXEC.
  - Illegal op (cmd_op > MAX_OP): ALU registers unchanged. rsp_data=32'hFFFF_FFFF, rsp_err=1. Go to RESP. acc_q unchanged.
- EXEC:
  - alu_* outputs are held stable throughout.
  - When counter≠0, decrement.
  - When counter==0, at that edge: rsp_data=alu_out, rsp_valid=1, go to RESP.
- Accumulator update at the capture edge: if the error condition is false, acc_q=alu_out.
- Error conditions, computed from the registered alu_a/alu_b/alu_sel:
  - div (9) with alu_b==0: rsp_err=1, rsp_data=32'hFFFF_FFFF, acc_q unchanged.
  - fact (4) with alu_a>12: rsp_err=1, same data and acc rules.
  - exp (5) with alu_a>22: rsp_err=1, same data and acc rules.
  - add (6) carry-out or sub (7) with a<b: result still written to acc_q; rsp_err=1.
- Latency for a legal op: rsp_valid rises SETTLE_CYCLES edges after the accepting edge. For an illegal op: 1 edge.
- RESP:
  - rsp_valid, rsp_data, rsp_err held until rsp_ready=1 at an edge, then rsp_valid=0, rsp_err=0, go to IDLE.
  - cmd_ready=0 while in RESP, so no command overlaps with a pending response.
  - rsp_ready=1 while rsp_valid=0 has no effect.
- Throughput: at most one command per SETTLE_CYCLES+2 cycles when rsp_ready is held high.
- Opcode 0 (clear) is a legal op; acc_q becomes 0 via alu_out.
- Reset asserted during EXEC or RESP: all state returns to reset values immediately; no capture occurs.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_CLEAR..OP_XOR (0..12) and OP_MAX;
  - FACT_MAX_IN=12 and EXP_MAX_IN=22;
  - ERR_DATA=32'hFFFF_FFFF;
  - state encoding for IDLE/EXEC/RESP.
- One sub-module is natural: alu_err_check, a combinational checker taking alu_sel, alu_a, alu_b, alu_out that produces err and acc_we. It is reusable by the ALU bench scoreboard.

Test Plan:
- Reset, then add a=3, b=4, SETTLE_CYCLES=1, rsp_ready=1 -> rsp_valid exactly 1 edge after accept; rsp_data=7, rsp_err=0, acc_q=7, cmd_ready low during EXEC/RESP.
- Chained op: acc_q=7, then mult with cmd_use_acc=1, b=6 -> alu_a=7, rsp_data=42, acc_q=42.
- div a=10, b=0 -> rsp_err=1, rsp_data=FFFF_FFFF, acc_q stays 42. Then fact a=13 -> rsp_err=1, acc_q unchanged.
- Illegal cmd_op=20 -> response 1 edge after accept, rsp_err=1, alu_sel unchanged from previous op, acc_q unchanged.
- Back-pressure: sub a=9, b=2 with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data=7 stable, cmd_valid held high is not accepted. rsp_ready=1 -> IDLE next edge, then the held command is accepted.
- Reset pulse mid-EXEC with SETTLE_CYCLES=4 -> all outputs 0 asynchronously, no rsp_valid; after release, a new clear op yields rsp_data=0.
